// File: rtl/rgb_yuv_pkg.sv
// Shared constants, types and arithmetic helpers for the RGB-to-YCbCr pipeline.
// BT.601 limited-range integer coefficients; see rgb_yuv_pipe for the optional RGB_YUV_SIDEBAND_EN build.
package rgb_yuv_pkg;

   localparam int COMP_W = 32'sd8;
   localparam int PROD_W = 32'sd18;
   localparam int SUM_W  = 32'sd19;

   localparam int FMT_565 = 32'sd0;
   localparam int FMT_888 = 32'sd1;

   localparam logic signed [8:0] K_YR =  9'sd66;
   localparam logic signed [8:0] K_YG =  9'sd129;
   localparam logic signed [8:0] K_YB =  9'sd25;
   localparam logic signed [8:0] K_UR = -9'sd38;
   localparam logic signed [8:0] K_UG = -9'sd74;
   localparam logic signed [8:0] K_UB =  9'sd112;
   localparam logic signed [8:0] K_VR =  9'sd112;
   localparam logic signed [8:0] K_VG = -9'sd94;
   localparam logic signed [8:0] K_VB = -9'sd18;

   localparam logic signed [SUM_W-1:0] Y_OFF = 19'sd16;
   localparam logic signed [SUM_W-1:0] C_OFF = 19'sd128;
   localparam logic signed [SUM_W-1:0] RND   = 19'sd128;
   localparam int SH = 32'sd8;

   typedef struct packed {
      logic [COMP_W-1:0] r;
      logic [COMP_W-1:0] g;
      logic [COMP_W-1:0] b;
   } pix888_t;

   typedef struct packed {
      logic signed [PROD_W-1:0] r;
      logic signed [PROD_W-1:0] g;
      logic signed [PROD_W-1:0] b;
   } prod3_t;

   function automatic logic signed [PROD_W-1:0] mul_k(input logic [COMP_W-1:0] c,
                                                      input logic signed [8:0] k);
      logic signed [PROD_W-1:0] a;
      logic signed [PROD_W-1:0] kk;
      a  = $signed({10'd0, c});
      kk = PROD_W'(k);
      return a * kk;
   endfunction

   function automatic prod3_t mul3(input pix888_t p,
                                   input logic signed [8:0] kr,
                                   input logic signed [8:0] kg,
                                   input logic signed [8:0] kb);
      prod3_t res;
      res.r = mul_k(p.r, kr);
      res.g = mul_k(p.g, kg);
      res.b = mul_k(p.b, kb);
      return res;
   endfunction

   // Round, floor-shift, offset and clamp one channel to [0,255].
   function automatic logic [COMP_W-1:0] finish(input prod3_t p,
                                                input logic signed [SUM_W-1:0] off);
      logic signed [SUM_W-1:0] s;
      logic signed [SUM_W-1:0] t;
      s = SUM_W'($signed(p.r)) + SUM_W'($signed(p.g)) + SUM_W'($signed(p.b)) + RND;
      t = (s >>> SH) + off;
      if (t < 19'sd0) begin
         return 8'd0;
      end else if (t > 19'sd255) begin
         return 8'd255;
      end else begin
         return t[COMP_W-1:0];
      end
   endfunction

endpackage

// File: rtl/rgb_expand.sv
// Combinational expansion of an RGB565 or RGB888 input word to 8 bits per channel.
// RGB565 channels replicate their MSBs into the new LSBs so full-scale stays full-scale.
module rgb_expand
   import rgb_yuv_pkg::*;
#(
   parameter int IN_FMT = FMT_565
) (
   input  logic [23:0] rgb_in,
   output pix888_t     pix
);

   generate
      if (IN_FMT == FMT_888) begin : g_888
         assign pix = rgb_in;
      end else begin : g_565
         logic [7:0] unused_hi;
         assign unused_hi = rgb_in[23:16];
         assign pix.r = {rgb_in[15:11], rgb_in[15:13]};
         assign pix.g = {rgb_in[10:5],  rgb_in[10:9]};
         assign pix.b = {rgb_in[4:0],   rgb_in[4:2]};
      end
   endgenerate

endmodule

// File: rtl/rgb_yuv_pipe.sv
// Three-stage RGB-to-YCbCr (BT.601 limited range) converter with valid/ready on both sides.
// Optional macro RGB_YUV_SIDEBAND_EN adds sof/eol flags that travel with each pixel.
module rgb_yuv_pipe
   import rgb_yuv_pkg::*;
#(
   parameter int IN_FMT = FMT_565
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [23:0]       rgb_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [COMP_W-1:0] y_out,
   output logic [COMP_W-1:0] u_out,
   output logic [COMP_W-1:0] v_out
`ifdef RGB_YUV_SIDEBAND_EN
   ,
   input  logic              in_sof,
   input  logic              in_eol,
   output logic              out_sof,
   output logic              out_eol
`endif
);

   logic    adv;
   logic    v1;
   logic    v2;
   pix888_t exp_pix;
   pix888_t s1_pix;
   prod3_t  py;
   prod3_t  pu;
   prod3_t  pv;

   // The whole pipe moves as one; a stalled output freezes every stage.
   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;

   rgb_expand #(.IN_FMT(IN_FMT)) u_expand (
      .rgb_in (rgb_in),
      .pix    (exp_pix)
   );

   // Stage valid bits, bubbles included.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
      end else if (adv) begin
         v1        <= in_valid;
         v2        <= v1;
         out_valid <= v2;
      end
   end

   // Datapath: expand, multiply, then round/offset/clamp into the output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_out <= 8'd0;
         u_out <= 8'd0;
         v_out <= 8'd0;
      end else if (adv) begin
         s1_pix <= exp_pix;
         py     <= mul3(s1_pix, K_YR, K_YG, K_YB);
         pu     <= mul3(s1_pix, K_UR, K_UG, K_UB);
         pv     <= mul3(s1_pix, K_VR, K_VG, K_VB);
         y_out  <= finish(py, Y_OFF);
         u_out  <= finish(pu, C_OFF);
         v_out  <= finish(pv, C_OFF);
      end
   end

`ifdef RGB_YUV_SIDEBAND_EN
   logic [1:0] sb1;
   logic [1:0] sb2;

   // Frame markers ride alongside their pixel through all three stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         sb1     <= 2'b00;
         sb2     <= 2'b00;
         out_sof <= 1'b0;
         out_eol <= 1'b0;
      end else if (adv) begin
         sb1     <= {in_sof, in_eol};
         sb2     <= sb1;
         out_sof <= sb2[1];
         out_eol <= sb2[0];
      end
   end
`endif

endmodule

// File: tb/tb_rgb_yuv_pipe.sv
// Scoreboard bench: two instances (RGB565 and RGB888) share one stimulus stream and are
// checked against a plain-arithmetic BT.601 reference model.
module tb_rgb_yuv_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [23:0] rgb_in;
   logic        out_ready;
   logic        in_ready0, in_ready1;
   logic        out_valid0, out_valid1;
   logic [7:0]  y0, u0, v0, y1, u1, v1;
   logic        in_sof, in_eol;
`ifdef RGB_YUV_SIDEBAND_EN
   logic        out_sof0, out_eol0, out_sof1, out_eol1;
`endif

   rgb_yuv_pipe #(.IN_FMT(0)) dut565 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .rgb_in(rgb_in),
      .out_valid(out_valid0), .out_ready(out_ready), .y_out(y0), .u_out(u0), .v_out(v0)
`ifdef RGB_YUV_SIDEBAND_EN
      , .in_sof(in_sof), .in_eol(in_eol), .out_sof(out_sof0), .out_eol(out_eol0)
`endif
   );

   rgb_yuv_pipe #(.IN_FMT(1)) dut888 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .rgb_in(rgb_in),
      .out_valid(out_valid1), .out_ready(out_ready), .y_out(y1), .u_out(u1), .v_out(v1)
`ifdef RGB_YUV_SIDEBAND_EN
      , .in_sof(in_sof), .in_eol(in_eol), .out_sof(out_sof1), .out_eol(out_eol1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         stamp;
      logic [23:0] e565;
      logic [23:0] e888;
      logic       sof;
      logic       eol;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   adv_cnt = 0;
   int   mode = 0;
   int   rdy_phase = 0;
   logic mon_en = 1'b0;

   function automatic int fdiv256(input int s);
      if (s >= 0) return s / 256;
      return -((-s + 255) / 256);
   endfunction

   function automatic int clamp8(input int x);
      if (x < 0) return 0;
      if (x > 255) return 255;
      return x;
   endfunction

   // Reference: BT.601 limited-range conversion written directly from the formulas.
   function automatic logic [23:0] model(input logic [23:0] pix, input int fmt);
      int r, g, b, yy, uu, vv;
      if (fmt == 0) begin
         r = int'(pix[15:11]); r = r * 8 + r / 4;
         g = int'(pix[10:5]);  g = g * 4 + g / 16;
         b = int'(pix[4:0]);   b = b * 8 + b / 4;
      end else begin
         r = int'(pix[23:16]);
         g = int'(pix[15:8]);
         b = int'(pix[7:0]);
      end
      yy = clamp8(fdiv256(66 * r + 129 * g + 25 * b + 128) + 16);
      uu = clamp8(fdiv256(-38 * r - 74 * g + 112 * b + 128) + 128);
      vv = clamp8(fdiv256(112 * r - 94 * g - 18 * b + 128) + 128);
      return {yy[7:0], uu[7:0], vv[7:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   // Downstream ready pattern generator.
   initial out_ready = 1'b1;
   always @(posedge clk) begin
      #1;
      case (mode)
         1: begin
            out_ready = (rdy_phase == 0 || rdy_phase == 3);
            rdy_phase = (rdy_phase + 1) % 4;
         end
         2: out_ready = ($urandom_range(0, 2) != 0);
         default: out_ready = 1'b1;
      endcase
   end

   // Output monitor.
   logic       after_rst = 1'b1;
   logic       prev_stall = 1'b0;
   logic [7:0] hy0, hu0, hv0, hy1, hu1, hv1;
   always @(negedge clk) begin
      logic adv_now;
      logic exp_valid;
      exp_t e;
      if (mon_en) begin
         adv_now = out_ready | ~out_valid0;
         chk("in_ready_eq_adv", {31'd0, in_ready0}, {31'd0, adv_now});
         chk("in_ready_match", {31'd0, in_ready1}, {31'd0, in_ready0});
         chk("out_valid_match", {31'd0, out_valid1}, {31'd0, out_valid0});
         if (after_rst) begin
            chk("rst_out_valid", {31'd0, out_valid0}, 32'd0);
            chk("rst_outputs", {8'd0, y0, u0, v0}, 32'd0);
            chk("rst_outputs888", {8'd0, y1, u1, v1}, 32'd0);
         end else begin
            exp_valid = (q.size() > 0) && (q[0].stamp + 2 == adv_cnt);
            chk("out_valid_timing", {31'd0, out_valid0}, {31'd0, exp_valid});
            if (prev_stall) begin
               chk("hold_valid", {31'd0, out_valid0}, 32'd1);
               chk("hold_565", {8'd0, y0, u0, v0}, {8'd0, hy0, hu0, hv0});
               chk("hold_888", {8'd0, y1, u1, v1}, {8'd0, hy1, hu1, hv1});
            end
            if (out_valid0 && out_ready && q.size() > 0) begin
               e = q.pop_front();
               chk("yuv565", {8'd0, y0, u0, v0}, {8'd0, e.e565});
               chk("yuv888", {8'd0, y1, u1, v1}, {8'd0, e.e888});
`ifdef RGB_YUV_SIDEBAND_EN
               chk("sideband565", {30'd0, out_sof0, out_eol0}, {30'd0, e.sof, e.eol});
               chk("sideband888", {30'd0, out_sof1, out_eol1}, {30'd0, e.sof, e.eol});
`endif
            end
         end
         prev_stall = out_valid0 && !out_ready && !rst;
         {hy0, hu0, hv0, hy1, hu1, hv1} = {y0, u0, v0, y1, u1, v1};
         after_rst = rst;
         if (rst) q.delete();
         else if (adv_now) adv_cnt++;
      end
   end

   // Present one pixel until accepted; expectation is queued at acceptance.
   task automatic send(input logic [23:0] pix, input logic sof, input logic eol);
      exp_t e;
      int   tries;
      in_valid = 1'b1;
      rgb_in   = pix;
      in_sof   = sof;
      in_eol   = eol;
      tries    = 0;
      forever begin
         @(negedge clk);
         #1;
         if (in_ready0) begin
            e.stamp = adv_cnt;
            e.e565  = model(pix, 0);
            e.e888  = model(pix, 1);
            e.sof   = sof;
            e.eol   = eol;
            q.push_back(e);
            @(posedge clk);
            #1;
            break;
         end
         tries++;
         if (tries > 1000) begin
            errors++;
            $display("FAIL accept_timeout actual=stalled expected=accepted");
            @(posedge clk);
            #1;
            break;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_eol   = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      rgb_in   = 24'd0;
      in_sof   = 1'b0;
      in_eol   = 1'b0;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;

      send(24'h008610, 1'b0, 1'b0);
      idle(4);

      send(24'hFFFFFF, 1'b1, 1'b0);
      send(24'h000000, 1'b0, 1'b0);
      send(24'hFF0000, 1'b0, 1'b0);
      send(24'h00FF00, 1'b0, 1'b1);
      idle(4);

      mode = 1;
      for (int i = 0; i < 8; i++) send(24'($urandom()), 1'b0, 1'b0);
      idle(6);
      mode = 0;
      idle(2);

      send(24'($urandom()), 1'b0, 1'b0);
      idle(1);
      send(24'($urandom()), 1'b0, 1'b0);
      send(24'($urandom()), 1'b0, 1'b0);
      idle(5);

      for (int i = 0; i < 3; i++) send(24'($urandom()), 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(24'h123456, 1'b1, 1'b1);
      idle(5);

      mode = 2;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         send(24'($urandom()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      mode = 0;
      idle(12);
      chk("drained", q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
